// File: rtl/alu_arbiter_if.sv
// Requester/response bundle between the two issuing units and alu_arbiter.
// master = issuing side, slave = arbiter side.
interface alu_arbiter_if #(
  parameter int CNT_W = 16
) ();
  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [31:0]       req0_a, req0_b, req1_a, req1_b;
  logic [1:0]        req0_ctrl, req1_ctrl;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [31:0]       rsp_result;
  logic [3:0]        rsp_flags;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_result, rsp_flags, busy, op_count
  );

  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
           req0_ctrl, req1_ctrl, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_result, rsp_flags, busy, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter in front of one 32-bit ALU: IDLE -> EXEC -> RESP, one op in flight.
// Define ALU_ARB_RR_EN for round-robin contention; default is fixed priority to port 0.

// Combinational 32-bit ALU: add/sub/and/or with {N,Z,C,V}.
module alu_arbiter_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [1:0]  ctrl_i,
  output logic [31:0] result_o,
  output logic [3:0]  flags_o
);
  logic [31:0] bx;
  logic [32:0] sum;
  logic        c, v;

  // sub is a + ~b + 1: invert b and use ctrl[0] as the carry-in
  assign bx  = ctrl_i[0] ? ~b_i : b_i;
  assign sum = {1'b0, a_i} + {1'b0, bx} + 33'(ctrl_i[0]);

  always_comb begin
    result_o = sum[31:0];
    c        = sum[32];
    v        = (a_i[31] == bx[31]) && (sum[31] != a_i[31]);
    if (ctrl_i[1]) begin
      result_o = ctrl_i[0] ? (a_i | b_i) : (a_i & b_i);
      c        = 1'b0;
      v        = 1'b0;
    end
  end

  assign flags_o = {result_o[31], (result_o == 32'd0), c, v};
endmodule

// Per-port handshake qualification.
module alu_arbiter_port (
  input  logic idle_i,
  input  logic resp_i,
  input  logic gnt_i,
  input  logic own_i,
  input  logic rsp_ready_i,
  output logic req_ready_o,
  output logic rsp_valid_o,
  output logic rsp_hs_o
);
  assign req_ready_o = idle_i & gnt_i;
  assign rsp_valid_o = resp_i & own_i;
  assign rsp_hs_o    = rsp_valid_o & rsp_ready_i;
endmodule

module alu_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_arbiter_if.slave  bus
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                          state_q, state_d;
  logic                            owner_q, owner_d;
  logic                            last_grant_q, last_grant_d;
  logic [31:0]                     a_q, a_d, b_q, b_d;
  logic [1:0]                      ctrl_q, ctrl_d;
  logic [31:0]                     result_q, result_d;
  logic [3:0]                      flags_q, flags_d;
  logic [CNT_W-1:0]                cnt_q, cnt_d;

  logic [NUM_PORTS-1:0]            req_valid, req_ready, rsp_valid, rsp_ready, rsp_hs, gnt;
  logic [NUM_PORTS-1:0][31:0]      req_a, req_b;
  logic [NUM_PORTS-1:0][1:0]       req_ctrl;
  logic                            pick1;
  logic [31:0]                     alu_res;
  logic [3:0]                      alu_flags;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign req_a     = {bus.req1_a, bus.req0_a};
  assign req_b     = {bus.req1_b, bus.req0_b};
  assign req_ctrl  = {bus.req1_ctrl, bus.req0_ctrl};

`ifdef ALU_ARB_RR_EN
  assign pick1 = ~last_grant_q;
`else
  assign pick1 = 1'b0;
  // last_grant is still tracked so the two builds share identical state
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // One-hot grant, empty when nobody requests
  always_comb begin
    gnt = '0;
    unique case (req_valid)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = pick1 ? 2'b10 : 2'b01;
      default: gnt = '0;
    endcase
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    alu_arbiter_port u_port (
      .idle_i      (state_q == IDLE),
      .resp_i      (state_q == RESP),
      .gnt_i       (gnt[p]),
      .own_i       (owner_q == 1'(p)),
      .rsp_ready_i (rsp_ready[p]),
      .req_ready_o (req_ready[p]),
      .rsp_valid_o (rsp_valid[p]),
      .rsp_hs_o    (rsp_hs[p])
    );
  end

  alu_arbiter_alu u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .ctrl_i   (ctrl_q),
    .result_o (alu_res),
    .flags_o  (alu_flags)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    flags_d      = flags_q;
    cnt_d        = cnt_q;
    unique case (state_q)
      IDLE: if (|gnt) begin
        owner_d      = gnt[1];
        last_grant_d = gnt[1];
        a_d          = req_a[gnt[1]];
        b_d          = req_b[gnt[1]];
        ctrl_d       = req_ctrl[gnt[1]];
        state_d      = EXEC;
      end
      EXEC: begin
        result_d = alu_res;
        flags_d  = alu_flags;
        state_d  = RESP;
      end
      RESP: if (|rsp_hs) begin
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      ctrl_q       <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.op_count   = cnt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed table plus randomized transactions against a spec-level model of alu_arbiter.
module tb_alu_arbiter;
  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] a, b;
    logic [1:0]  c;
  } op_t;

  typedef struct {
    bit          v0, v1;
    op_t         o0, o1;
    int          hold;
    bit          late1;
    bit          win;
    logic [31:0] res;
    logic [3:0]  fl;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.CNT_W(CNT_W)) bus ();
  alu_arbiter #(.CNT_W(CNT_W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus.slave));

  int total = 0;
  int bad   = 0;
  bit m_last = 1'b1;
  int m_cnt  = 0;
  bit rr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic op_t mkop(logic [31:0] a, logic [31:0] b, logic [1:0] c);
    op_t o;
    o.a = a; o.b = b; o.c = c;
    return o;
  endfunction

  // Reference ALU from arithmetic definitions: returns {N,Z,C,V, result}
  function automatic logic [35:0] ref_alu(op_t o);
    longint ua = {32'd0, o.a};
    longint ub = {32'd0, o.b};
    longint sa = $signed(o.a);
    longint sb = $signed(o.b);
    longint s  = 0;
    logic [31:0] r;
    bit cy = 0, v = 0;
    case (o.c)
      2'd0: begin r = o.a + o.b; cy = (ua + ub) > 64'hFFFF_FFFF; s = sa + sb; end
      2'd1: begin r = o.a - o.b; cy = (ua >= ub);                s = sa - sb; end
      2'd2: r = o.a & o.b;
      default: r = o.a | o.b;
    endcase
    if (o.c[1] == 1'b0) v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    return {r[31], (r == 32'd0), cy, v, r};
  endfunction

  // Expected winner given which ports request and the previous grant
  function automatic bit pick(bit v0, bit v1, bit last);
    if (v0 && v1) return rr ? ~last : 1'b0;
    return v1;
  endfunction

  task automatic txn(input string tag, input bit v0, input bit v1, input op_t o0, input op_t o1,
                     input int hold, input bit late1, input bit win,
                     input logic [31:0] res, input logic [3:0] fl);
    bit p0, p1, w2;
    logic [1:0] exp_rdy;
    bus.req0_valid = v0; bus.req0_a = o0.a; bus.req0_b = o0.b; bus.req0_ctrl = o0.c;
    bus.req1_valid = v1; bus.req1_a = o1.a; bus.req1_b = o1.b; bus.req1_ctrl = o1.c;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    #1;
    chk({tag, " req_ready"}, {bus.req1_ready, bus.req0_ready}, win ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    m_last = win;
    if (win) bus.req1_valid = 1'b0; else bus.req0_valid = 1'b0;
    if (late1) bus.req1_valid = 1'b1;
    chk({tag, " exec"}, {bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready},
        5'b10000);
    @(posedge clk); #1;
    chk({tag, " rsp_valid"}, {bus.busy, bus.rsp1_valid, bus.rsp0_valid}, {1'b1, win, !win});
    chk({tag, " result"}, {bus.rsp_flags, bus.rsp_result}, {fl, res});
    for (int i = 0; i < hold; i++) begin
      // the non-owner's rsp_ready must not complete the op
      if (win) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
      @(posedge clk); #1;
      chk({tag, " hold"}, {bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready,
                           bus.rsp_flags, bus.rsp_result}, {win, !win, 2'b00, fl, res});
    end
    bus.rsp0_ready = !win; bus.rsp1_ready = win;
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    m_cnt++;
    p0 = bus.req0_valid; p1 = bus.req1_valid;
    w2 = pick(p0, p1, m_last);
    exp_rdy = (p0 || p1) ? (w2 ? 2'b10 : 2'b01) : 2'b00;
    chk({tag, " done"}, {bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready,
                         bus.op_count}, {1'b0, 2'b00, exp_rdy, CNT_W'(m_cnt)});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[10];
    op_t  add12, sub33, c0, c1;
    logic [35:0] e;
    int sel;
`ifdef ALU_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.req0_a = 0; bus.req0_b = 0; bus.req0_ctrl = 0;
    bus.req1_a = 0; bus.req1_b = 0; bus.req1_ctrl = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;

    add12 = mkop(32'd1, 32'd2, 2'b00);
    sub33 = mkop(32'd3, 32'd3, 2'b01);
    tbl[0] = '{1, 0, mkop(32'hFFFFFFFF, 32'h1, 2'b00), add12, 0, 0, 0, 32'h0, 4'b0110};
    tbl[1] = '{0, 1, add12, mkop(32'h80000000, 32'h1, 2'b01), 0, 0, 1, 32'h7FFFFFFF, 4'b0011};
    tbl[2] = '{1, 0, mkop(32'hF0F0F0F0, 32'hFF00FF00, 2'b10), mkop(32'h12340000, 32'h5678, 2'b11),
               5, 1, 0, 32'hF000F000, 4'b1000};
    tbl[3] = '{0, 1, add12, mkop(32'h12340000, 32'h5678, 2'b11), 0, 0, 1, 32'h12345678, 4'b0000};
    tbl[4] = '{1, 0, mkop(32'd5, 32'd7, 2'b01), add12, 1, 0, 0, 32'hFFFFFFFE, 4'b1000};
    tbl[5] = '{0, 1, add12, mkop(32'h7FFFFFFF, 32'h1, 2'b00), 0, 0, 1, 32'h80000000, 4'b1001};
    for (int i = 6; i < 10; i++) begin
      bit w = rr ? (i % 2 == 1) : 1'b0;
      tbl[i] = '{1, 1, add12, sub33, 0, 0, w, w ? 32'd0 : 32'd3, w ? 4'b0110 : 4'b0000};
    end

    // Reset state
    #1;
    chk("reset outputs", {bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready,
                          bus.rsp_flags, bus.rsp_result, bus.op_count}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    foreach (tbl[i])
      txn($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].o0, tbl[i].o1, tbl[i].hold,
          tbl[i].late1, tbl[i].win, tbl[i].res, tbl[i].fl);
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(posedge clk); #1;

    // Reset mid-EXEC discards the operation
    bus.req0_valid = 1; bus.req0_a = 32'h55; bus.req0_b = 32'h11; bus.req0_ctrl = 2'b00;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    chk("pre-reset exec", {bus.busy, bus.rsp0_valid}, 2'b10);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset", {bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.req1_ready, bus.req0_ready,
                        bus.rsp_flags, bus.rsp_result, bus.op_count}, 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_last = 1'b1; m_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post-reset quiet", {bus.busy, bus.rsp1_valid, bus.rsp0_valid, bus.op_count}, 0);
    end

    // Randomized traffic; a pending loser keeps its operation unchanged
    c0 = add12; c1 = add12;
    for (int n = 0; n < 17; n++) begin
      bit v0, v1, w;
      op_t o;
      sel = $urandom_range(1, 3);
      v0 = sel[0] || bus.req0_valid;
      v1 = sel[1] || bus.req1_valid;
      if (!bus.req0_valid) c0 = mkop($urandom, (n % 4 == 0) ? 32'h1 : $urandom, 2'($urandom_range(0, 3)));
      if (!bus.req1_valid) c1 = mkop((n % 5 == 0) ? 32'h80000000 : $urandom, $urandom, 2'($urandom_range(0, 3)));
      w = pick(v0, v1, m_last);
      o = w ? c1 : c0;
      e = ref_alu(o);
      txn($sformatf("rnd%0d", n), v0, v1, c0, c1, $urandom_range(0, 2), 0, w, e[31:0], e[35:32]);
    end
    chk("op_count wrap", bus.op_count, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
